antisat_seq_lock: RTL and testbench

//  Parametrised, clocked Anti-SAT locking block. It taps N primary inputs of the host circuit and

---
 rtl/antisat_seq_lock_pkg.sv | 17 +
 rtl/antisat_seq_lock_if.sv | 27 ++
 rtl/antisat_flip_core.sv | 19 +
 rtl/antisat_seq_lock.sv | 98 +++++++++
 tb/tb_antisat_seq_lock.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/antisat_seq_lock_pkg.sv
// Shared types and helpers for the serial-key Anti-SAT lock.
// Optional flip-event counter: ANTISAT_FLIP_CNT_EN.
package antisat_pkg;

  typedef enum logic [1:0] {
    AS_IDLE,
    AS_LOAD,
    AS_ARMED
  } as_state_t;

  localparam int AS_CNT_W_DEFAULT = 16;

  function automatic int key_w(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/antisat_seq_lock_if.sv
// Serial key-load handshake between key source and lock.
// Optional flip-event counter: ANTISAT_FLIP_CNT_EN.
interface antisat_seq_lock_if;

  logic key_valid;
  logic key_bit;
  logic key_ready;
  logic key_clear;
  logic key_loaded;

  modport master (
    output key_valid,
    output key_bit,
    output key_clear,
    input  key_ready,
    input  key_loaded
  );

  modport slave (
    input  key_valid,
    input  key_bit,
    input  key_clear,
    output key_ready,
    output key_loaded
  );

endinterface

// File: rtl/antisat_flip_core.sv
// Combinational Anti-SAT flip term: g & ~g' over the tapped inputs.
// Optional flip-event counter: ANTISAT_FLIP_CNT_EN.
module antisat_flip_core #(
  parameter int N = 4
) (
  input  logic [N-1:0] tap_in,
  input  logic [N-1:0] k1,
  input  logic [N-1:0] k2,
  output logic         flip
);

  logic g;
  logic gbar;

  assign g    = &(tap_in ^ k1);
  assign gbar = ~&(tap_in ^ k2);
  assign flip = g & gbar;

endmodule

// File: rtl/antisat_seq_lock.sv
// Serial-key Anti-SAT lock: FSM, key shifter, registered output.
// Optional flip-event counter: ANTISAT_FLIP_CNT_EN.
module antisat_seq_lock
  import antisat_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = AS_CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  antisat_seq_lock_if.slave   key_if,
  input  logic [N-1:0]        tap_in,
  input  logic                sig_in,
  output logic                sig_out
`ifdef ANTISAT_FLIP_CNT_EN
  ,
  output logic [CNT_W-1:0]    flip_cnt
`endif
);

  localparam int KW = key_w(N);
  localparam int BW = $clog2(KW + 1);

  if (N < 2 || CNT_W < 1) begin : g_param_chk
    $error("antisat_seq_lock: N must be >= 2 and CNT_W >= 1");
  end

  as_state_t         state;
  logic [KW-1:0]     key_q;
  logic [BW-1:0]     bcnt;
  logic              flip;

  antisat_flip_core #(.N(N)) u_core (
    .tap_in (tap_in),
    .k1     (key_q[N-1:0]),
    .k2     (key_q[KW-1:N]),
    .flip   (flip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= AS_IDLE;
      key_q             <= '0;
      bcnt              <= '0;
      sig_out           <= 1'b0;
      key_if.key_ready  <= 1'b0;
      key_if.key_loaded <= 1'b0;
    end else if (key_if.key_clear) begin
      state             <= AS_IDLE;
      key_q             <= '0;
      bcnt              <= '0;
      sig_out           <= 1'b0;
      key_if.key_ready  <= 1'b0;
      key_if.key_loaded <= 1'b0;
    end else begin
      sig_out <= (state == AS_ARMED) & (sig_in ^ flip);
      unique case (state)
        AS_IDLE: begin
          state            <= AS_LOAD;
          key_if.key_ready <= 1'b1;
        end
        AS_LOAD: begin
          if (key_if.key_valid) begin
            key_q <= {key_if.key_bit, key_q[KW-1:1]};
            bcnt  <= bcnt + 1'b1;
            // last bit arms on the same edge it is shifted in
            if (bcnt == BW'(KW - 1)) begin
              state             <= AS_ARMED;
              key_if.key_ready  <= 1'b0;
              key_if.key_loaded <= 1'b1;
            end
          end
        end
        AS_ARMED: begin
          state <= AS_ARMED;
        end
        default: begin
          state             <= AS_IDLE;
          key_if.key_ready  <= 1'b0;
          key_if.key_loaded <= 1'b0;
        end
      endcase
    end
  end

`ifdef ANTISAT_FLIP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flip_cnt <= '0;
    end else if (key_if.key_clear) begin
      flip_cnt <= '0;
    end else if (state == AS_ARMED && flip && flip_cnt != '1) begin
      flip_cnt <= flip_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_antisat_seq_lock.sv
// Scoreboard bench for antisat_seq_lock (N=2).
// Counter checks run when ANTISAT_FLIP_CNT_EN is defined.
module tb_antisat_seq_lock;

  localparam int N  = 2;
  localparam int KW = 2 * N;
`ifdef ANTISAT_FLIP_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  tap_in;
  logic          sig_in;
  logic          sig_out;
`ifdef ANTISAT_FLIP_CNT_EN
  logic [CW-1:0] flip_cnt;
`endif

  antisat_seq_lock_if kif();

  antisat_seq_lock #(
    .N     (N),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_if   (kif),
    .tap_in   (tap_in),
    .sig_in   (sig_in),
    .sig_out  (sig_out)
`ifdef ANTISAT_FLIP_CNT_EN
    ,
    .flip_cnt (flip_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic exp_q[$];
  logic dummy;

  int            m_st;
  logic [KW-1:0] m_key;
  int            m_bits;
  int            m_cnt;

  // wrong keys flip exactly when tap_in == ~k1
  function automatic logic m_flip();
    logic [N-1:0] k1;
    logic [N-1:0] k2;
    k1 = m_key[N-1:0];
    k2 = m_key[KW-1:N];
    return (k1 != k2) && (tap_in == ~k1);
  endfunction

  task automatic tick();
    logic f;
    f = m_flip();
    exp_q.push_back((m_st == 2 && !kif.key_clear) ? (sig_in ^ f) : 1'b0);
    if (kif.key_clear) begin
      m_st = 0; m_key = '0; m_bits = 0; m_cnt = 0;
    end else begin
      case (m_st)
        0: m_st = 1;
        1: if (kif.key_valid) begin
          m_key = {kif.key_bit, m_key[KW-1:1]};
          m_bits++;
          if (m_bits == KW) m_st = 2;
        end
        default: if (f && m_cnt < (1 << CW) - 1) m_cnt++;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    kif.key_valid = 1'b0;
    kif.key_clear = 1'b0;
    m_st = 0; m_key = '0; m_bits = 0; m_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic b);
    kif.key_valid = 1'b1;
    kif.key_bit   = b;
    tick();
    kif.key_valid = 1'b0;
    dummy = exp_q.pop_front();
  endtask

  task automatic test_reset();
    logic e;
    rst = 1'b1;
    #2;
    total++;
    if (sig_out !== 1'b0) begin
      bad++; $display("FAIL reset_sig_out: got %0b want 0", sig_out);
    end
    total++;
    if (kif.key_ready !== 1'b0) begin
      bad++; $display("FAIL reset_key_ready: got %0b want 0", kif.key_ready);
    end
    total++;
    if (kif.key_loaded !== 1'b0) begin
      bad++; $display("FAIL reset_key_loaded: got %0b want 0", kif.key_loaded);
    end
`ifdef ANTISAT_FLIP_CNT_EN
    total++;
    if (flip_cnt !== '0) begin
      bad++; $display("FAIL reset_flip_cnt: got %0d want 0", flip_cnt);
    end
`endif
    do_reset();
    tick();
    e = exp_q.pop_front();
    total++;
    if (sig_out !== e) begin
      bad++; $display("FAIL idle_sig_out: got %0b want %0b", sig_out, e);
    end
    total++;
    if (kif.key_ready !== 1'b1) begin
      bad++; $display("FAIL load_key_ready: got %0b want 1", kif.key_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    logic e;
    do_reset();
    tick();
    dummy = exp_q.pop_front();
    send(1'b1);
    send(1'b1);
    do_reset();
    total++;
    if (kif.key_ready !== 1'b0 || kif.key_loaded !== 1'b0 || sig_out !== 1'b0) begin
      bad++;
      $display("FAIL midload_reset: got rdy=%0b ld=%0b out=%0b want 0 0 0",
               kif.key_ready, kif.key_loaded, sig_out);
    end
    tick();
    dummy = exp_q.pop_front();
    send(1'b0);
    send(1'b0);
    send(1'b1);
    total++;
    if (kif.key_loaded !== 1'b0) begin
      bad++; $display("FAIL midload_partial: got loaded=%0b want 0", kif.key_loaded);
    end
    send(1'b1);
    total++;
    if (kif.key_loaded !== 1'b1) begin
      bad++; $display("FAIL midload_full: got loaded=%0b want 1", kif.key_loaded);
    end
    tap_in = 2'b11;
    sig_in = 1'b0;
    tick();
    e = exp_q.pop_front();
    total++;
    if (sig_out !== e) begin
      bad++; $display("FAIL midload_flip: got %0b want %0b", sig_out, e);
    end
  endtask

  task automatic test_pre_armed();
    logic e;
    do_reset();
    sig_in = 1'b1;
    tick();
    dummy = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      sig_in        = ~sig_in;
      tap_in        = N'(i);
      kif.key_valid = 1'b1;
      kif.key_bit   = i[0];
      tick();
      e = exp_q.pop_front();
      total++;
      if (sig_out !== e || kif.key_loaded !== 1'b0) begin
        bad++;
        $display("FAIL pre_armed[%0d]: got out=%0b ld=%0b want %0b 0",
                 i, sig_out, kif.key_loaded, e);
      end
    end
    kif.key_valid = 1'b0;
  endtask

  task automatic test_correct_key();
    logic e;
    do_reset();
    tick();
    dummy = exp_q.pop_front();
    send(1'b1); send(1'b0); send(1'b1); send(1'b0);
    for (int t = 0; t < 4; t++) begin
      for (int s = 0; s < 2; s++) begin
        tap_in = N'(t);
        sig_in = s[0];
        tick();
        e = exp_q.pop_front();
        total++;
        if (sig_out !== e) begin
          bad++;
          $display("FAIL good_key tap=%0d sig=%0d: got %0b want %0b", t, s, sig_out, e);
        end
      end
    end
  endtask

  task automatic test_wrong_key();
    logic e;
    do_reset();
    tick();
    dummy = exp_q.pop_front();
    send(1'b0); send(1'b0); send(1'b1); send(1'b1);
    tap_in = 2'b11; sig_in = 1'b0;
    tick();
    e = exp_q.pop_front();
    total++;
    if (sig_out !== 1'b1 || e !== 1'b1) begin
      bad++; $display("FAIL wrong_key_flip: got %0b want 1", sig_out);
    end
    tap_in = 2'b01;
    tick();
    e = exp_q.pop_front();
    total++;
    if (sig_out !== e) begin
      bad++; $display("FAIL wrong_key_noflip: got %0b want %0b", sig_out, e);
    end
    for (int i = 0; i < 10; i++) begin
      tap_in = N'($urandom_range(3, 0));
      sig_in = 1'($urandom_range(1, 0));
      tick();
      e = exp_q.pop_front();
      total++;
      if (sig_out !== e) begin
        bad++; $display("FAIL wrong_key_rand[%0d]: got %0b want %0b", i, sig_out, e);
      end
    end
  endtask

  task automatic test_armed_hold_and_clear();
    logic e;
    tap_in = 2'b11; sig_in = 1'b0;
    kif.key_valid = 1'b1;
    kif.key_bit   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      e = exp_q.pop_front();
      total++;
      if (sig_out !== e || kif.key_ready !== 1'b0) begin
        bad++;
        $display("FAIL armed_hold[%0d]: got out=%0b rdy=%0b want %0b 0",
                 i, sig_out, kif.key_ready, e);
      end
    end
    kif.key_clear = 1'b1;
    tick();
    e = exp_q.pop_front();
    kif.key_clear = 1'b0;
    kif.key_valid = 1'b0;
    total++;
    if (sig_out !== e || kif.key_loaded !== 1'b0 || kif.key_ready !== 1'b0) begin
      bad++;
      $display("FAIL clear: got out=%0b ld=%0b rdy=%0b want %0b 0 0",
               sig_out, kif.key_loaded, kif.key_ready, e);
    end
    tick();
    dummy = exp_q.pop_front();
    total++;
    if (kif.key_ready !== 1'b1) begin
      bad++; $display("FAIL clear_reload_ready: got %0b want 1", kif.key_ready);
    end
  endtask

`ifdef ANTISAT_FLIP_CNT_EN
  task automatic test_flip_cnt();
    logic e;
    do_reset();
    tick();
    dummy = exp_q.pop_front();
    send(1'b0); send(1'b0); send(1'b1); send(1'b1);
    tap_in = 2'b11; sig_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = exp_q.pop_front();
      total++;
      if (sig_out !== e) begin
        bad++; $display("FAIL cnt_sig_out[%0d]: got %0b want %0b", i, sig_out, e);
      end
    end
    total++;
    if (flip_cnt !== CW'(m_cnt) || flip_cnt !== 2'd3) begin
      bad++; $display("FAIL flip_cnt_sat: got %0d want %0d", flip_cnt, m_cnt);
    end
    kif.key_clear = 1'b1;
    tick();
    dummy = exp_q.pop_front();
    kif.key_clear = 1'b0;
    total++;
    if (flip_cnt !== '0) begin
      bad++; $display("FAIL flip_cnt_clear: got %0d want 0", flip_cnt);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    tap_in        = '0;
    sig_in        = 1'b0;
    kif.key_valid = 1'b0;
    kif.key_bit   = 1'b0;
    kif.key_clear = 1'b0;
    test_reset();
    test_reset_mid_load();
    test_pre_armed();
    test_correct_key();
    test_wrong_key();
    test_armed_hold_and_clear();
`ifdef ANTISAT_FLIP_CNT_EN
    test_flip_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
